mem_access_stage: RTL

Memory-access stage of the pipelined MIPS core. It sits between the execute stage and write-back, consuming the execute stage's outputs: ALU result as address, forwarded rt data, memory-write and word/byte controls, register-write controls and destination number. It drives a handshaked data-memory port, stalls the upstream pipeline while an access is outstanding, and presents one registered write-back packet per retired instruction.

---
 rtl/mem_access_stage_pkg.sv | 30 +++
 rtl/mem_access_stage_if.sv | 21 ++
 rtl/mem_access_stage_lane_align.sv | 22 ++
 rtl/mem_access_stage.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MIPS memory-access stage.
package mem_access_stage_pkg;

  localparam int TIMEOUT_CYCLES = 255;
  localparam int CNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic [1:0] REG_SRC_ALU = 2'b00;
  localparam logic [1:0] REG_SRC_MEM = 2'b01;
  localparam logic [1:0] REG_SRC_PC4 = 2'b10;

  localparam logic [4:0] REG_RA = 5'd31;

  // Encoding 2'b11 falls back to the ALU result.
  function automatic logic [31:0] wb_select(input logic [1:0] src, input logic [31:0] alu,
                                            input logic [31:0] ld, input logic [31:0] pc4);
    case (src)
      REG_SRC_MEM: return ld;
      REG_SRC_PC4: return pc4;
      default:     return alu;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory port. mem_req, address, data and enables stay stable until mem_ready is
// sampled high on a rising edge; mem_ready seen while no request is pending is ignored.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage_lane_align.sv
// Byte-lane steering: store enables/replicated data, and load lane extraction with
// sign extension for byte loads.
module mem_lane_align (
  input  logic [1:0]  st_lane,
  input  logic        st_is_word,
  input  logic [31:0] st_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_lane,
  input  logic        ld_is_word,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);
  logic [7:0] ld_byte;

  always_comb begin
    byte_en = st_is_word ? 4'b1111 : (4'b0001 << st_lane);
    wdata   = st_is_word ? st_data : {4{st_data[7:0]}};
    ld_byte = rdata[{ld_lane, 3'b000} +: 8];
    ld_data = ld_is_word ? rdata : {{24{ld_byte[7]}}, ld_byte};
  end
endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues handshaked data-memory accesses, stalls upstream while one
// is outstanding and emits one registered write-back packet per retired instruction.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] ALU_result,
  input  logic [31:0] rt_data,
  input  logic        is_mem_op,
  input  logic        we_memory,
  input  logic        is_word,
  input  logic        register_write,
  input  logic [1:0]  register_src,
  input  logic [31:0] pc4,
  input  logic [4:0]  rd_num,
  input  logic        halted_in,
  output logic        stall,
  mem_access_stage_if.master mem,
  output logic        wb_valid,
  output logic        wb_reg_we,
  output logic [4:0]  wb_rd_num,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        mem_error,
  output logic        halted,
  output state_t      dbg_state
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_next;
  logic             timeout;
  logic [1:0]       lane_q;
  logic             word_q;
  logic [1:0]       src_q;
  logic             rw_q;
  logic             halt_q;
  logic [31:0]      alu_q;
  logic [31:0]      pc4_q;
  logic             mis_op;
  logic             accept_mem;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

  assign mis_op     = is_mem_op & is_word & (ALU_result[1:0] != 2'b00);
  assign accept_mem = in_valid & is_mem_op & ~mis_op;
  assign cnt_next   = {1'b0, cnt} + 9'd1;
  assign timeout    = (cnt_next == 9'(TIMEOUT_CYCLES));
  assign stall      = ~reset & ((state != IDLE) | accept_mem);
  assign dbg_state  = state;

  mem_lane_align u_lane (
    .st_lane    (ALU_result[1:0]),
    .st_is_word (is_word),
    .st_data    (rt_data),
    .byte_en    (st_be),
    .wdata      (st_wdata),
    .ld_lane    (lane_q),
    .ld_is_word (word_q),
    .rdata      (mem.mem_rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      lane_q          <= '0;
      word_q          <= 1'b0;
      src_q           <= '0;
      rw_q            <= 1'b0;
      halt_q          <= 1'b0;
      alu_q           <= '0;
      pc4_q           <= '0;
      mem.mem_req     <= 1'b0;
      mem.mem_we      <= 1'b0;
      mem.mem_addr    <= '0;
      mem.mem_wdata   <= '0;
      mem.mem_byte_en <= '0;
      wb_valid        <= 1'b0;
      wb_reg_we       <= 1'b0;
      wb_rd_num       <= '0;
      wb_data         <= '0;
      misaligned      <= 1'b0;
      mem_error       <= 1'b0;
      halted          <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
      mem_error  <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          wb_rd_num <= rd_num;
          halt_q    <= halted_in;
          if (accept_mem) begin
            mem.mem_req     <= 1'b1;
            mem.mem_we      <= we_memory;
            mem.mem_addr    <= {ALU_result[31:2], 2'b00};
            mem.mem_wdata   <= st_wdata;
            mem.mem_byte_en <= st_be;
            lane_q          <= ALU_result[1:0];
            word_q          <= is_word;
            src_q           <= register_src;
            rw_q            <= register_write;
            alu_q           <= ALU_result;
            pc4_q           <= pc4;
            cnt             <= '0;
            state           <= ACCESS;
          end else begin
            // No load data exists here, so a load-sourced result reads as zero.
            wb_valid   <= 1'b1;
            wb_data    <= wb_select(register_src, ALU_result, 32'd0, pc4);
            wb_reg_we  <= register_write & ~mis_op;
            misaligned <= mis_op;
            if (halted_in) state <= DONE;
          end
        end
        ACCESS: begin
          cnt <= cnt_next[CNT_W-1:0];
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            wb_valid    <= 1'b1;
            wb_data     <= wb_select(src_q, alu_q, ld_data, pc4_q);
            wb_reg_we   <= rw_q;
            state       <= DONE;
          end else if (timeout) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            wb_valid    <= 1'b1;
            wb_data     <= wb_select(src_q, alu_q, 32'd0, pc4_q);
            wb_reg_we   <= 1'b0;
            mem_error   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          halted <= halt_q;
          state  <= halt_q ? HALT : IDLE;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule
